// File: rtl/cpu16_ctrl_pkg.sv
// Shared encodings for the cpu16 multi-cycle controller: states, opcodes and
// the ALU/PC datapath select codes.
package cpu16_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StExecR   = 4'd2,
    StExecI   = 4'd3,
    StMemAddr = 4'd4,
    StMemRd   = 4'd5,
    StMemWr   = 4'd6,
    StWbR     = 4'd7,
    StWbMem   = 4'd8,
    StBranch  = 4'd9,
    StJump    = 4'd10,
    StHalt    = 4'd11
  } state_e;

  localparam logic [3:0] OP_RTYPE_A = 4'b0000;
  localparam logic [3:0] OP_RTYPE_B = 4'b0001;
  localparam logic [3:0] OP_SHIFT   = 4'b0010;
  localparam logic [3:0] OP_LW      = 4'b0100;
  localparam logic [3:0] OP_SW      = 4'b0101;
  localparam logic [3:0] OP_BEQ     = 4'b0110;
  localparam logic [3:0] OP_J       = 4'b0111;
  localparam logic [3:0] OP_ADDI    = 4'b1001;
  localparam logic [3:0] OP_SUBI    = 4'b1010;
  localparam logic [3:0] OP_SLTI    = 4'b1011;
  localparam logic [3:0] OP_HALT    = 4'b1111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_CONST2 = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // State reached from DECODE; undefined opcodes map to StFetch.
  function automatic state_e decode_target(input logic [3:0] op);
    state_e tgt;
    case (op)
      OP_RTYPE_A, OP_RTYPE_B:              tgt = StExecR;
      OP_SHIFT, OP_ADDI, OP_SUBI, OP_SLTI: tgt = StExecI;
      OP_LW, OP_SW:                        tgt = StMemAddr;
      OP_BEQ:                              tgt = StBranch;
      OP_J:                                tgt = StJump;
      OP_HALT:                             tgt = StHalt;
      default:                             tgt = StFetch;
    endcase
    return tgt;
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Controller <-> datapath bundle. Illegal exists only when ILLEGAL_TRAP_EN is defined.
interface multicycle_control_fsm_if;
  logic [3:0] opcode;
  logic       Zero;
  logic       MemReady;
  logic       PCWrite;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSource;
  logic       InstrDone;
  logic       Halted;
  logic       BusErr;
  logic [3:0] State;
`ifdef ILLEGAL_TRAP_EN
  logic       Illegal;

  modport master (
    input  opcode, Zero, MemReady,
    output PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
    output ALUSrcA, ALUSrcB, ALUOp, PCSource, InstrDone, Halted, BusErr, State, Illegal
  );
  modport slave (
    output opcode, Zero, MemReady,
    input  PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
    input  ALUSrcA, ALUSrcB, ALUOp, PCSource, InstrDone, Halted, BusErr, State, Illegal
  );
`else
  modport master (
    input  opcode, Zero, MemReady,
    output PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
    output ALUSrcA, ALUSrcB, ALUOp, PCSource, InstrDone, Halted, BusErr, State
  );
  modport slave (
    output opcode, Zero, MemReady,
    input  PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
    input  ALUSrcA, ALUSrcB, ALUOp, PCSource, InstrDone, Halted, BusErr, State
  );
`endif
endinterface

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready cycles in a memory-wait state and flags a stall timeout.
module mem_wait_timer #(
  parameter int unsigned WAIT_MAX = 15,
  parameter int unsigned CNT_W    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic active,
  input  logic ready,
  output logic timeout
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
    end else if (active && !ready && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // A ready on the limit cycle still completes the access.
  assign timeout = (WAIT_MAX != 0) && active && !ready && (cnt_q == CNT_W'(WAIT_MAX));

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle cpu16 control FSM. Define ILLEGAL_TRAP_EN to trap undefined opcodes
// into HALT with a sticky Illegal flag; otherwise they retire as NOPs.
module multicycle_control_fsm
  import cpu16_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15,
  parameter int unsigned CNT_W    = 4
) (
  input logic                      Clock,
  input logic                      Reset,
  multicycle_control_fsm_if.master bus
);

  state_e state_q, state_d;
  logic   buserr_q;
  logic   regdst_q;
  logic   timeout;
  logic   in_wait;
  logic   state_chg;
  logic   op_legal;
`ifdef ILLEGAL_TRAP_EN
  logic   illegal_q;
`endif

  assign op_legal  = (decode_target(bus.opcode) != StFetch);
  assign in_wait   = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
  assign state_chg = (state_d != state_q);

  mem_wait_timer #(
    .WAIT_MAX (WAIT_MAX),
    .CNT_W    (CNT_W)
  ) u_wait_timer (
    .clk     (Clock),
    .rst     (Reset),
    .clear   (state_chg),
    .active  (in_wait),
    .ready   (bus.MemReady),
    .timeout (timeout)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch:  if (bus.MemReady) state_d = StDecode;
      StDecode: begin
        state_d = decode_target(bus.opcode);
`ifdef ILLEGAL_TRAP_EN
        if (!op_legal) state_d = StHalt;
`endif
      end
      StExecR, StExecI: state_d = StWbR;
      StMemAddr: state_d = (bus.opcode == OP_SW) ? StMemWr : StMemRd;
      StMemRd:   if (bus.MemReady) state_d = StWbMem;
      StMemWr:   if (bus.MemReady) state_d = StFetch;
      StHalt:    state_d = StHalt;
      default:   state_d = StFetch;
    endcase
    if (timeout) state_d = StHalt;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= StFetch;
      buserr_q <= 1'b0;
      regdst_q <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (timeout) buserr_q <= 1'b1;
      if (state_q == StExecR) regdst_q <= 1'b1;
      else if (state_q == StExecI) regdst_q <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
      if ((state_q == StDecode) && !op_legal) illegal_q <= 1'b1;
`endif
    end
  end

  // Strobes decode from the state; reset and the timeout cycle squash all of them.
  always_comb begin
    bus.PCWrite   = 1'b0;
    bus.IorD      = 1'b0;
    bus.MemRead   = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.IRWrite   = 1'b0;
    bus.MemtoReg  = 1'b0;
    bus.RegDst    = 1'b0;
    bus.RegWrite  = 1'b0;
    bus.ALUSrcA   = 1'b0;
    bus.ALUSrcB   = SRCB_RT;
    bus.ALUOp     = ALUOP_ADD;
    bus.PCSource  = PCSRC_ALU;
    bus.InstrDone = 1'b0;
    if (!Reset && !timeout) begin
      case (state_q)
        StFetch: begin
          bus.MemRead = 1'b1;
          bus.IRWrite = bus.MemReady;
          bus.PCWrite = bus.MemReady;
          bus.ALUSrcB = SRCB_CONST2;
        end
        StDecode: begin
          bus.ALUSrcB = SRCB_IMM_SH;
`ifndef ILLEGAL_TRAP_EN
          bus.InstrDone = !op_legal;
`endif
        end
        StExecR: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUOp   = ALUOP_RTYPE;
        end
        StExecI: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUSrcB = SRCB_IMM;
          bus.ALUOp   = ALUOP_ITYPE;
        end
        StMemAddr: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUSrcB = SRCB_IMM;
        end
        StMemRd: begin
          bus.MemRead = 1'b1;
          bus.IorD    = 1'b1;
        end
        StMemWr: begin
          bus.MemWrite  = 1'b1;
          bus.IorD      = 1'b1;
          bus.InstrDone = bus.MemReady;
        end
        StWbR: begin
          bus.RegWrite  = 1'b1;
          bus.RegDst    = regdst_q;
          bus.InstrDone = 1'b1;
        end
        StWbMem: begin
          bus.RegWrite  = 1'b1;
          bus.MemtoReg  = 1'b1;
          bus.InstrDone = 1'b1;
        end
        StBranch: begin
          bus.ALUSrcA   = 1'b1;
          bus.ALUOp     = ALUOP_SUB;
          bus.PCSource  = PCSRC_ALUOUT;
          bus.PCWrite   = bus.Zero;
          bus.InstrDone = 1'b1;
        end
        StJump: begin
          bus.PCWrite   = 1'b1;
          bus.PCSource  = PCSRC_JUMP;
          bus.InstrDone = 1'b1;
        end
        default: ;
      endcase
    end
    bus.Halted = !Reset && (state_q == StHalt);
    bus.BusErr = !Reset && buserr_q;
    bus.State  = Reset ? 4'd0 : 4'(state_q);
`ifdef ILLEGAL_TRAP_EN
    bus.Illegal = !Reset && illegal_q;
`endif
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: per-cycle expected output vectors
// are queued as stimulus is applied and compared when the outputs settle.
module tb_multicycle_control_fsm;

  typedef logic [21:0] vec_t;
  typedef struct {
    logic rdy;
    logic z;
    logic r;
    vec_t want;
  } stim_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;
  vec_t sb[$];

  multicycle_control_fsm_if bus ();

  multicycle_control_fsm #(
    .WAIT_MAX (15),
    .CNT_W    (4)
  ) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector: {PCWrite,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,ALUSrcA,
  //          ALUSrcB,ALUOp,PCSource,InstrDone,Halted,BusErr,State}
  function automatic vec_t mk(input logic [3:0] st, input logic [8:0] stb,
                              input logic [1:0] srcb, input logic [1:0] aop,
                              input logic [1:0] pcs, input logic [2:0] flg);
    return {stb, srcb, aop, pcs, flg, st};
  endfunction

  function automatic vec_t obs();
    return {bus.PCWrite, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite, bus.MemtoReg,
            bus.RegDst, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.PCSource,
            bus.InstrDone, bus.Halted, bus.BusErr, bus.State};
  endfunction

  function automatic vec_t e_fetch(input logic rdy);
    return mk(4'd0, {rdy, 1'b0, 1'b1, 1'b0, rdy, 4'b0000}, 2'b01, 2'b00, 2'b00, 3'b000);
  endfunction
  function automatic vec_t e_decode(input logic done);
    return mk(4'd1, 9'b0, 2'b11, 2'b00, 2'b00, {done, 2'b00});
  endfunction
  function automatic vec_t e_exec_r();
    return mk(4'd2, 9'b000000001, 2'b00, 2'b10, 2'b00, 3'b000);
  endfunction
  function automatic vec_t e_exec_i();
    return mk(4'd3, 9'b000000001, 2'b10, 2'b11, 2'b00, 3'b000);
  endfunction
  function automatic vec_t e_wb_r(input logic rd);
    return mk(4'd7, {6'b000000, rd, 2'b10}, 2'b00, 2'b00, 2'b00, 3'b100);
  endfunction
  function automatic vec_t e_mem_addr();
    return mk(4'd4, 9'b000000001, 2'b10, 2'b00, 2'b00, 3'b000);
  endfunction
  function automatic vec_t e_mem_rd();
    return mk(4'd5, 9'b011000000, 2'b00, 2'b00, 2'b00, 3'b000);
  endfunction
  function automatic vec_t e_mem_wr(input logic done);
    return mk(4'd6, 9'b010100000, 2'b00, 2'b00, 2'b00, {done, 2'b00});
  endfunction
  function automatic vec_t e_wb_mem();
    return mk(4'd8, 9'b000001010, 2'b00, 2'b00, 2'b00, 3'b100);
  endfunction
  function automatic vec_t e_branch(input logic z);
    return mk(4'd9, {z, 8'b00000001}, 2'b00, 2'b01, 2'b01, 3'b100);
  endfunction
  function automatic vec_t e_jump();
    return mk(4'd10, 9'b100000000, 2'b00, 2'b00, 2'b10, 3'b100);
  endfunction
  function automatic vec_t e_halt(input logic berr);
    return mk(4'd11, 9'b0, 2'b00, 2'b00, 2'b00, {2'b01, berr});
  endfunction
  function automatic vec_t e_zero();
    return mk(4'd0, 9'b0, 2'b00, 2'b00, 2'b00, 3'b000);
  endfunction

  function automatic stim_t s(input logic rdy, input logic z, input logic r, input vec_t want);
    stim_t t;
    t.rdy  = rdy;
    t.z    = z;
    t.r    = r;
    t.want = want;
    return t;
  endfunction

  task automatic apply(input stim_t t);
    bus.MemReady = t.rdy;
    bus.Zero     = t.z;
    rst          = t.r;
    sb.push_back(t.want);
    @(negedge clk);
  endtask

  task automatic test_reset();
    stim_t tbl[$];
    vec_t  want, got;
    tbl.push_back(s(1'b1, 1'b1, 1'b1, e_zero()));
    tbl.push_back(s(1'b0, 1'b1, 1'b1, e_zero()));
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
      want = sb.pop_front();
      got  = obs();
      n_cmp++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL reset[%0d]: got %h want %h", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rtype();
    stim_t tbl[$];
    vec_t  want, got;
    bus.opcode = 4'b0001;
    tbl.push_back(s(1'b1, 1'b0, 1'b0, e_fetch(1'b1)));
    tbl.push_back(s(1'b1, 1'b0, 1'b0, e_decode(1'b0)));
    tbl.push_back(s(1'b1, 1'b0, 1'b0, e_exec_r()));
    tbl.push_back(s(1'b1, 1'b0, 1'b0, e_wb_r(1'b1)));
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
      want = sb.pop_front();
      got  = obs();
      n_cmp++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL rtype[%0d]: got %h want %h", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_itype();
    stim_t tbl[$];
    vec_t  want, got;
    bus.opcode = 4'b1001;
    tbl.push_back(s(1'b1, 1'b0, 1'b0, e_fetch(1'b1)));
    tbl.push_back(s(1'b1, 1'b0, 1'b0, e_decode(1'b0)));
    tbl.push_back(s(1'b1, 1'b0, 1'b0, e_exec_i()));
    tbl.push_back(s(1'b1, 1'b0, 1'b0, e_wb_r(1'b0)));
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
      want = sb.pop_front();
      got  = obs();
      n_cmp++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL itype[%0d]: got %h want %h", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lw();
    stim_t tbl[$];
    vec_t  want, got;
    bus.opcode = 4'b0100;
    tbl.push_back(s(1'b1, 1'b0, 1'b0, e_fetch(1'b1)));
    tbl.push_back(s(1'b1, 1'b0, 1'b0, e_decode(1'b0)));
    tbl.push_back(s(1'b1, 1'b0, 1'b0, e_mem_addr()));
    for (int k = 0; k < 3; k++) tbl.push_back(s(1'b0, 1'b0, 1'b0, e_mem_rd()));
    tbl.push_back(s(1'b1, 1'b0, 1'b0, e_mem_rd()));
    tbl.push_back(s(1'b1, 1'b0, 1'b0, e_wb_mem()));
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
      want = sb.pop_front();
      got  = obs();
      n_cmp++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL lw[%0d]: got %h want %h", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sw();
    stim_t tbl[$];
    vec_t  want, got;
    bus.opcode = 4'b0101;
    tbl.push_back(s(1'b0, 1'b0, 1'b0, e_fetch(1'b0)));
    tbl.push_back(s(1'b1, 1'b0, 1'b0, e_fetch(1'b1)));
    tbl.push_back(s(1'b1, 1'b0, 1'b0, e_decode(1'b0)));
    tbl.push_back(s(1'b1, 1'b0, 1'b0, e_mem_addr()));
    tbl.push_back(s(1'b0, 1'b0, 1'b0, e_mem_wr(1'b0)));
    tbl.push_back(s(1'b0, 1'b0, 1'b0, e_mem_wr(1'b0)));
    tbl.push_back(s(1'b1, 1'b0, 1'b0, e_mem_wr(1'b1)));
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
      want = sb.pop_front();
      got  = obs();
      n_cmp++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL sw[%0d]: got %h want %h", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_beq();
    stim_t tbl[$];
    vec_t  want, got;
    bus.opcode = 4'b0110;
    tbl.push_back(s(1'b1, 1'b0, 1'b0, e_fetch(1'b1)));
    tbl.push_back(s(1'b1, 1'b0, 1'b0, e_decode(1'b0)));
    tbl.push_back(s(1'b1, 1'b1, 1'b0, e_branch(1'b1)));
    tbl.push_back(s(1'b1, 1'b1, 1'b0, e_fetch(1'b1)));
    tbl.push_back(s(1'b1, 1'b1, 1'b0, e_decode(1'b0)));
    tbl.push_back(s(1'b1, 1'b0, 1'b0, e_branch(1'b0)));
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
      want = sb.pop_front();
      got  = obs();
      n_cmp++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL beq[%0d]: got %h want %h", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_jump();
    stim_t tbl[$];
    vec_t  want, got;
    bus.opcode = 4'b0111;
    tbl.push_back(s(1'b1, 1'b0, 1'b0, e_fetch(1'b1)));
    tbl.push_back(s(1'b1, 1'b0, 1'b0, e_decode(1'b0)));
    tbl.push_back(s(1'b1, 1'b0, 1'b0, e_jump()));
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
      want = sb.pop_front();
      got  = obs();
      n_cmp++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL jump[%0d]: got %h want %h", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    stim_t tbl[$];
    vec_t  want, got;
    bus.opcode = 4'b1100;
    tbl.push_back(s(1'b1, 1'b0, 1'b0, e_fetch(1'b1)));
`ifdef ILLEGAL_TRAP_EN
    tbl.push_back(s(1'b1, 1'b0, 1'b0, e_decode(1'b0)));
    tbl.push_back(s(1'b1, 1'b0, 1'b0, e_halt(1'b0)));
    tbl.push_back(s(1'b0, 1'b0, 1'b0, e_halt(1'b0)));
    tbl.push_back(s(1'b1, 1'b0, 1'b1, e_zero()));
`else
    tbl.push_back(s(1'b1, 1'b0, 1'b0, e_decode(1'b1)));
`endif
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
      want = sb.pop_front();
      got  = obs();
      n_cmp++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL illegal[%0d]: got %h want %h", i, got, want);
      end
`ifdef ILLEGAL_TRAP_EN
      if (tbl[i].want[3:0] == 4'd11) begin
        n_cmp++;
        if (bus.Illegal !== 1'b1) begin
          n_fail++;
          $display("FAIL illegal_flag[%0d]: got %b want 1", i, bus.Illegal);
        end
      end
`endif
      @(posedge clk); #1;
    end
  endtask

  // Ready arriving on the limit cycle must beat the timeout.
  task automatic test_ready_wins();
    stim_t tbl[$];
    vec_t  want, got;
    bus.opcode = 4'b0111;
    for (int k = 0; k < 15; k++) tbl.push_back(s(1'b0, 1'b0, 1'b0, e_fetch(1'b0)));
    tbl.push_back(s(1'b1, 1'b0, 1'b0, e_fetch(1'b1)));
    tbl.push_back(s(1'b1, 1'b0, 1'b0, e_decode(1'b0)));
    tbl.push_back(s(1'b1, 1'b0, 1'b0, e_jump()));
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
      want = sb.pop_front();
      got  = obs();
      n_cmp++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL ready_wins[%0d]: got %h want %h", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_write();
    stim_t tbl[$];
    vec_t  want, got;
    bus.opcode = 4'b0101;
    tbl.push_back(s(1'b1, 1'b0, 1'b0, e_fetch(1'b1)));
    tbl.push_back(s(1'b1, 1'b0, 1'b0, e_decode(1'b0)));
    tbl.push_back(s(1'b1, 1'b0, 1'b0, e_mem_addr()));
    tbl.push_back(s(1'b0, 1'b0, 1'b0, e_mem_wr(1'b0)));
    tbl.push_back(s(1'b0, 1'b0, 1'b0, e_mem_wr(1'b0)));
    tbl.push_back(s(1'b0, 1'b0, 1'b1, e_zero()));
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
      want = sb.pop_front();
      got  = obs();
      n_cmp++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL reset_mid_write[%0d]: got %h want %h", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  // Starts in FETCH right after a reset, so the limit cycle is the 16th one.
  task automatic test_timeout();
    stim_t tbl[$];
    vec_t  want, got;
    for (int k = 0; k < 15; k++) tbl.push_back(s(1'b0, 1'b0, 1'b0, e_fetch(1'b0)));
    tbl.push_back(s(1'b0, 1'b0, 1'b0, e_zero()));
    tbl.push_back(s(1'b1, 1'b0, 1'b0, e_halt(1'b1)));
    tbl.push_back(s(1'b0, 1'b0, 1'b0, e_halt(1'b1)));
    tbl.push_back(s(1'b1, 1'b0, 1'b0, e_halt(1'b1)));
    tbl.push_back(s(1'b1, 1'b0, 1'b1, e_zero()));
    tbl.push_back(s(1'b0, 1'b0, 1'b0, e_fetch(1'b0)));
    tbl.push_back(s(1'b1, 1'b0, 1'b0, e_fetch(1'b1)));
    tbl.push_back(s(1'b1, 1'b0, 1'b0, e_decode(1'b0)));
    tbl.push_back(s(1'b1, 1'b0, 1'b0, e_mem_addr()));
    tbl.push_back(s(1'b1, 1'b0, 1'b0, e_mem_wr(1'b1)));
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
      want = sb.pop_front();
      got  = obs();
      n_cmp++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL timeout[%0d]: got %h want %h", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    n_cmp        = 0;
    n_fail       = 0;
    rst          = 1'b1;
    bus.opcode   = 4'b0000;
    bus.Zero     = 1'b0;
    bus.MemReady = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_rtype();
    test_itype();
    test_lw();
    test_sw();
    test_beq();
    test_jump();
    test_illegal();
    test_ready_wins();
    test_reset_mid_write();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Main control state machine for the multi-cycle 16-bit CPU.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives every datapath strobe plus the 2-bit ALUOp consumed by the ALU control decoder.
- Handles memory wait-states through a ready handshake, with a stall timeout that halts the core.

Parameters:
- WAIT_MAX, 15: maximum consecutive MemReady-low cycles tolerated in any memory state. 0 disables the timeout.
- CNT_W, 4: width of the wait counter. Must hold WAIT_MAX.

Ports:
- Clock  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high reset
- opcode  in  4  IR[15:12]; stable from DECODE onward
- Zero  in  1  ALU zero flag, combinational, same cycle
- MemReady  in  1  memory access complete this cycle
- PCWrite  out  1  PC load enable (branch condition already merged)
- IorD  out  1  memory address select: 0=PC, 1=ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  IR load enable
- MemtoReg  out  1  writeback data select: 1=MDR
- RegDst  out  1  destination register select: 1=rd (R-format)
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  ALU A input: 0=PC, 1=rs
- ALUSrcB  out  2  ALU B input: 00=rt, 01=const 2, 10=sign-ext imm, 11=sign-ext imm<<1
- ALUOp  out  2  00=add, 01=sub/compare, 10=R-format via Funct, 11=I-format
- PCSource  out  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target
- InstrDone  out  1  one-cycle pulse on the last cycle of each instruction
- Halted  out  1  core is in HALT
- BusErr  out  1  sticky: memory timeout occurred
- State  out  4  current state encoding, for debug

Behaviour:
- Moore outputs decoded from the state register. Exceptions: PCWrite and IRWrite are also gated by MemReady/Zero as noted below.
- Reset: state <= FETCH, wait counter <= 0, BusErr <= 0. While Reset is high, all outputs are forced to 0.
- State encodings: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, MEM_ADDR=4, MEM_RD=5, MEM_WR=6, WB_R=7, WB_MEM=8, BRANCH=9, JUMP=10, HALT=11. Codes 12-15 are unused and go to FETCH.
- FETCH:
  - Drives MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite = PCWrite = MemReady.
  - Stays in FETCH until MemReady, then goes to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (precomputes the branch target). Next state by opcode:
  - 0000, 0001 -> EXEC_R
  - 0010, 1001, 1010, 1011 -> EXEC_I
  - 0100 (LW), 0101 (SW) -> MEM_ADDR
  - 0110 (BEQ) -> BRANCH
  - 0111 (J) -> JUMP
  - 1111 (HALT) -> HALT
  - any other opcode -> see Optional Feature
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next: WB_R with RegDst=1.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=11. Next: WB_R with RegDst=0.
- RegDst is registered and latched on the EXEC_R/EXEC_I exit.
- WB_R: RegWrite=1, MemtoReg=0. InstrDone=1. Next: FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: MEM_RD if LW, MEM_WR if SW.
- MEM_RD: MemRead=1, IorD=1. Waits for MemReady, then goes to WB_MEM.
- MEM_WR: MemWrite=1, IorD=1. Waits for MemReady; on MemReady sets InstrDone=1 and goes to FETCH.
- WB_MEM: RegWrite=1, MemtoReg=1, RegDst=0. InstrDone=1. Next: FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01, PCWrite=Zero. InstrDone=1. Next: FETCH.
- JUMP: PCWrite=1, PCSource=10. InstrDone=1. Next: FETCH.
- HALT: Halted=1, all strobes 0. Leaves only on Reset.
- Wait counter:
  - Clears on entry to FETCH, MEM_RD and MEM_WR.
  - Increments each cycle MemReady=0 in those states, saturating.
  - Timeout condition: WAIT_MAX!=0, counter==WAIT_MAX, and MemReady=0. On timeout: BusErr <= 1, next state HALT, and all strobes for that cycle are suppressed.
  - If MemReady=1 on the timeout cycle, MemReady wins and normal progress continues.
- Reset asserted mid-access or mid-wait aborts immediately. The next cycle is FETCH with the counter at 0.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined: an undefined opcode in DECODE sets a sticky Illegal output (1-bit, reset 0) and goes to HALT. InstrDone is not pulsed.
- Not defined: an undefined opcode executes as a NOP. DECODE goes to FETCH with InstrDone=1, and the Illegal port is absent.

Decomposition:
- Shared package cpu16_ctrl_pkg holds:
  - state enum
  - opcode constants (OP_RTYPE_A=0000, OP_RTYPE_B=0001, OP_SHIFT=0010, OP_LW=0100, OP_SW=0101, OP_BEQ=0110, OP_J=0111, OP_ADDI=1001, OP_SUBI=1010, OP_SLTI=1011, OP_HALT=1111)
  - ALUOp, ALUSrcB and PCSource encodings
- One sub-module: mem_wait_timer, holding the wait counter, saturation and timeout compare.

Test Plan:
- Reset, then opcode=0001 with MemReady=1 always -> state sequence 0,1,2,7,0. ALUOp=10 in EXEC_R. RegWrite=1 and RegDst=1 only in WB_R. InstrDone pulses once.
- LW (0100) with MemReady low 3 cycles in MEM_RD -> MEM_RD held 4 cycles with MemRead=1, IorD=1. Then WB_MEM with MemtoReg=1, RegWrite=1.
- BEQ (0110): run once with Zero=1 -> PCWrite=1, PCSource=01 in BRANCH. Run again with Zero=0 -> PCWrite=0.
- WAIT_MAX=15, MemReady held 0 in FETCH -> after 16 FETCH cycles BusErr=1, then Halted=1 until Reset. Reset clears both and returns to FETCH.
- Reset asserted during MEM_WR wait -> MemWrite=0 the next cycle, State=0, counter 0.
- Opcode 1100 -> with ILLEGAL_TRAP_EN: Illegal=1, Halted=1. Without it: back to FETCH with InstrDone=1.
